// File: rtl/jk_pkg.sv
// Shared types and constants for the JK latch-bank driver.
// JK codes are packed as {j, k}.
package jk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SETTLE = 2'd2,
    CHECK  = 2'd3
  } state_t;

  localparam logic [1:0] HOLD   = 2'b00;
  localparam logic [1:0] RESET  = 2'b01;
  localparam logic [1:0] SET    = 2'b10;
  localparam logic [1:0] TOGGLE = 2'b11;

  localparam int SETTLE_MIN = 1;
  localparam int SETTLE_MAX = 15;
  localparam int RETRY_MAX  = 7;

  // Counter widths cover the parameter maxima above.
  localparam int SETTLE_W = 4;
  localparam int RETRY_W  = 3;

endpackage

// File: rtl/jk_latch_driver_excite.sv
// Combinational per-word JK excitation: bits that already match hold,
// bits that differ get a set/reset code, or the toggle code when selected.
module jk_excite
  import jk_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] cur,
  input  logic [W-1:0] tgt,
  input  logic         use_toggle,
  output logic [W-1:0] j,
  output logic [W-1:0] k
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    logic [1:0] code;

    always_comb begin
      code = HOLD;
      if (cur[i] != tgt[i]) begin
        if (use_toggle) code = TOGGLE;
        else            code = tgt[i] ? SET : RESET;
      end
    end

    assign j[i] = code[1];
    assign k[i] = code[0];
  end

endmodule

// File: rtl/jk_latch_driver.sv
// Command side of a JK latch bank: takes a target word, pulses the bank
// with the needed J/K excitation, waits to settle, verifies Q and retries.
module jk_latch_driver
  import jk_pkg::*;
#(
  parameter int W          = 8,
  parameter int SETTLE_CYC = 2,
  parameter int MAX_RETRY  = 2,
  parameter int USE_TOGGLE = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tgt_valid,
  input  logic [W-1:0] tgt_data,
  output logic         tgt_ready,
  input  logic [W-1:0] q_fb,
  output logic [W-1:0] j,
  output logic [W-1:0] k,
  output logic         en,
  output logic         busy,
  output logic         done,
  output logic         err
);

  // Handshake: a target transfers on a rising edge where tgt_valid and
  // tgt_ready are both high; tgt_ready is high only in IDLE outside reset.

  localparam logic TOGGLE_MODE = (USE_TOGGLE != 0);

  state_t              state, state_n;
  logic [W-1:0]        tgt_q, tgt_q_n;
  logic [W-1:0]        j_n, k_n, ex_j, ex_k, ex_tgt;
  logic                en_n;
  logic [RETRY_W-1:0]  retry, retry_n;
  logic [SETTLE_W-1:0] settle, settle_n;
  logic                match;

  // In IDLE the excitation is computed against the word being offered,
  // afterwards against the captured target.
  assign ex_tgt = (state == IDLE) ? tgt_data : tgt_q;
  assign match  = (q_fb == tgt_q);

  jk_excite #(.W(W)) u_excite (
    .cur        (q_fb),
    .tgt        (ex_tgt),
    .use_toggle (TOGGLE_MODE),
    .j          (ex_j),
    .k          (ex_k)
  );

  assign tgt_ready = (state == IDLE) && !rst;
  assign busy      = (state != IDLE);

  always_comb begin
    state_n  = state;
    tgt_q_n  = tgt_q;
    retry_n  = retry;
    settle_n = settle;
    j_n      = '0;
    k_n      = '0;
    en_n     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    unique case (state)
      IDLE: begin
        if (tgt_valid) begin
          tgt_q_n = tgt_data;
          retry_n = '0;
          if (q_fb == tgt_data) begin
            state_n = CHECK;
          end else begin
            state_n = DRIVE;
            j_n     = ex_j;
            k_n     = ex_k;
            en_n    = 1'b1;
          end
        end
      end
      DRIVE: begin
        state_n  = SETTLE;
        settle_n = SETTLE_W'(SETTLE_CYC);
      end
      SETTLE: begin
        settle_n = settle - 1'b1;
        if (settle <= SETTLE_W'(1)) state_n = CHECK;
      end
      CHECK: begin
        if (match) begin
          done    = 1'b1;
          state_n = IDLE;
        end else if (retry < RETRY_W'(MAX_RETRY)) begin
          retry_n = retry + 1'b1;
          state_n = DRIVE;
          j_n     = ex_j;
          k_n     = ex_k;
          en_n    = 1'b1;
        end else begin
          err     = 1'b1;
          state_n = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      tgt_q  <= '0;
      retry  <= '0;
      settle <= '0;
      j      <= '0;
      k      <= '0;
      en     <= 1'b0;
    end else begin
      state  <= state_n;
      tgt_q  <= tgt_q_n;
      retry  <= retry_n;
      settle <= settle_n;
      j      <= j_n;
      k      <= k_n;
      en     <= en_n;
    end
  end

endmodule
